// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction (i) and data (d) requesters; requests pass with zero latency,
// responses route combinationally in request order. Granting stalls when DEPTH requests are outstanding.
module mem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [AW-1:0]   i_req_addr,
    input  logic [DW-1:0]   i_req_wdata,
    input  logic            i_req_wen,
    input  logic [DW/8-1:0] i_req_wmask,
    output logic            i_resp_valid,
    output logic [DW-1:0]   i_resp_data,

    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [AW-1:0]   d_req_addr,
    input  logic [DW-1:0]   d_req_wdata,
    input  logic            d_req_wen,
    input  logic [DW/8-1:0] d_req_wmask,
    output logic            d_resp_valid,
    output logic [DW-1:0]   d_resp_data,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_wen,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_resp_valid,
    input  logic [DW-1:0]   mem_resp_data,

    output logic            err_unexp
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_WAIT + 1);

    logic [DEPTH-1:0] ids;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [SW-1:0]    starve_cnt;

    logic grant_en;
    logic d_sel;
    logic i_sel;
    logic hs;
    logic pop;

    // i overrides d only once it has lost MAX_WAIT handshakes in a row
    assign d_sel    = d_req_valid && !((starve_cnt == SW'(MAX_WAIT)) && i_req_valid);
    assign i_sel    = i_req_valid && !d_sel;
    assign grant_en = reset && (count != CW'(DEPTH));
    assign hs       = mem_req_valid && mem_req_ready;
    assign pop      = reset && mem_resp_valid && (count != '0);

    always_comb begin
        mem_req_valid = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wen       = 1'b0;
        mem_wmask     = '0;
        i_req_ready   = 1'b0;
        d_req_ready   = 1'b0;
        i_resp_valid  = 1'b0;
        i_resp_data   = '0;
        d_resp_valid  = 1'b0;
        d_resp_data   = '0;
        if (grant_en) begin
            if (d_sel) begin
                mem_req_valid = 1'b1;
                mem_addr      = d_req_addr;
                mem_wdata     = d_req_wdata;
                mem_wen       = d_req_wen;
                mem_wmask     = d_req_wmask;
                d_req_ready   = mem_req_ready;
            end else if (i_sel) begin
                mem_req_valid = 1'b1;
                mem_addr      = i_req_addr;
                mem_wdata     = i_req_wdata;
                mem_wen       = i_req_wen;
                mem_wmask     = i_req_wmask;
                i_req_ready   = mem_req_ready;
            end
        end
        if (pop) begin
            if (ids[rd_ptr]) begin
                d_resp_valid = 1'b1;
                d_resp_data  = mem_resp_data;
            end else begin
                i_resp_valid = 1'b1;
                i_resp_data  = mem_resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ids        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            err_unexp  <= 1'b0;
        end else begin
            if (hs) begin
                ids[wr_ptr] <= d_sel;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (hs && !pop) begin
                count <= count + CW'(1);
            end else if (!hs && pop) begin
                count <= count - CW'(1);
            end
            if (mem_resp_valid && (count == '0)) begin
                err_unexp <= 1'b1;
            end
            if (!i_req_valid || (hs && i_sel)) begin
                starve_cnt <= '0;
            end else if (hs && d_sel && (starve_cnt != SW'(MAX_WAIT))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_req_wen, i_resp_valid;
    logic [31:0] i_req_addr, i_req_wdata, i_resp_data;
    logic [3:0]  i_req_wmask;
    logic        d_req_valid, d_req_ready, d_req_wen, d_resp_valid;
    logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
    logic [3:0]  d_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_resp_data;
    logic [3:0]  mem_wmask;
    logic        err_unexp;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_seq;

    mem_arbiter #(.AW(32), .DW(32), .DEPTH(4), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_wen(i_req_wen), .i_req_wmask(i_req_wmask),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_wen(d_req_wen), .d_req_wmask(d_req_wmask),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .err_unexp(err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_req_wen = 1'b0; i_req_wmask = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_wen = 1'b0; d_req_wmask = '0;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // reset holds everything quiet even with a request pending
        i_req_valid = 1'b1; i_req_addr = 32'h100;
        #3;
        chk1("rst_i_ready", i_req_ready, 1'b0);
        chk1("rst_mem_valid", mem_req_valid, 1'b0);
        chk1("rst_err", err_unexp, 1'b0);

        // i-only read, response two cycles after the grant
        @(negedge clk); reset = 1'b1;
        #1;
        chk1("i_grant_valid", mem_req_valid, 1'b1);
        chk32("i_grant_addr", mem_addr, 32'h100);
        chk1("i_grant_ready", i_req_ready, 1'b1);
        chk1("i_grant_d_ready", d_req_ready, 1'b0);
        @(negedge clk); i_req_valid = 1'b0;
        #1;
        chk1("idle_mem_valid", mem_req_valid, 1'b0);
        chk32("idle_mem_addr", mem_addr, 32'h0);
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
        #1;
        chk1("i_resp_valid", i_resp_valid, 1'b1);
        chk32("i_resp_data", i_resp_data, 32'hDEADBEEF);
        chk1("i_resp_d_quiet", d_resp_valid, 1'b0);
        @(negedge clk); mem_resp_valid = 1'b0;
        #1;
        chk1("i_resp_drop", i_resp_valid, 1'b0);
        chk32("i_resp_data_zero", i_resp_data, 32'h0);

        // starvation limit: both valid, responses keep the queue at one entry
        exp_seq = 10'b0111101111;
        i_req_addr = 32'h40; d_req_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_req_valid = 1'b1; d_req_valid = 1'b1;
            mem_resp_valid = (k > 0); mem_resp_data = k;
            #1;
            chk1($sformatf("starve_d_ready_%0d", k), d_req_ready, exp_seq[k]);
            chk1($sformatf("starve_i_ready_%0d", k), i_req_ready, !exp_seq[k]);
            if (k > 0) chk1($sformatf("starve_route_%0d", k), d_resp_valid, exp_seq[k-1]);
        end
        @(negedge clk); i_req_valid = 1'b0; d_req_valid = 1'b0; mem_resp_valid = 1'b1;
        #1;
        chk1("starve_drain_i", i_resp_valid, 1'b1);
        @(negedge clk); mem_resp_valid = 1'b0;

        // grants i,d,d,i fill the queue
        @(negedge clk); i_req_valid = 1'b1;
        #1; chk1("fill_g0_i", i_req_ready, 1'b1);
        @(negedge clk); i_req_valid = 1'b0; d_req_valid = 1'b1;
        #1; chk1("fill_g1_d", d_req_ready, 1'b1);
        @(negedge clk);
        #1; chk1("fill_g2_d", d_req_ready, 1'b1);
        @(negedge clk); d_req_valid = 1'b0; i_req_valid = 1'b1;
        #1; chk1("fill_g3_i", i_req_ready, 1'b1);
        @(negedge clk); d_req_valid = 1'b1;
        #1;
        chk1("full_i_ready", i_req_ready, 1'b0);
        chk1("full_d_ready", d_req_ready, 1'b0);
        chk1("full_mem_valid", mem_req_valid, 1'b0);
        @(negedge clk); d_req_valid = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hA;
        #1;
        chk1("full_pop_no_grant", i_req_ready, 1'b0);
        chk1("full_pop_mem_valid", mem_req_valid, 1'b0);
        chk1("resp_a_i_valid", i_resp_valid, 1'b1);
        chk32("resp_a_i_data", i_resp_data, 32'hA);
        chk1("resp_a_d_quiet", d_resp_valid, 1'b0);
        @(negedge clk); mem_resp_data = 32'hB;
        #1;
        chk1("after_pop_grant", i_req_ready, 1'b1);
        chk1("resp_b_d_valid", d_resp_valid, 1'b1);
        chk32("resp_b_d_data", d_resp_data, 32'hB);
        chk1("resp_b_i_quiet", i_resp_valid, 1'b0);
        @(negedge clk); i_req_valid = 1'b0; mem_resp_data = 32'hC;
        #1;
        chk1("resp_c_d_valid", d_resp_valid, 1'b1);
        chk32("resp_c_d_data", d_resp_data, 32'hC);
        @(negedge clk); mem_resp_data = 32'hD;
        #1;
        chk1("resp_d_i_valid", i_resp_valid, 1'b1);
        chk32("resp_d_i_data", i_resp_data, 32'hD);
        @(negedge clk); mem_resp_data = 32'hE;
        #1;
        chk1("resp_e_i_valid", i_resp_valid, 1'b1);
        chk32("resp_e_i_data", i_resp_data, 32'hE);
        @(negedge clk); mem_resp_valid = 1'b0;

        // unexpected response with nothing outstanding
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
        #1;
        chk1("unexp_i_quiet", i_resp_valid, 1'b0);
        chk1("unexp_d_quiet", d_resp_valid, 1'b0);
        @(negedge clk); mem_resp_valid = 1'b0;
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 32'h200;
        d_req_wdata = 32'h12345678; d_req_wmask = 4'b0101;
        #1;
        chk1("err_set", err_unexp, 1'b1);
        chk1("wr_d_ready", d_req_ready, 1'b1);
        chk1("wr_mem_wen", mem_wen, 1'b1);
        chk32("wr_mem_wdata", mem_wdata, 32'h12345678);
        chk32("wr_mem_wmask", {28'h0, mem_wmask}, 32'h5);
        @(negedge clk); d_req_valid = 1'b0; d_req_wen = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
        #1;
        chk1("wr_resp_d_valid", d_resp_valid, 1'b1);
        chk32("wr_resp_d_data", d_resp_data, 32'h77);
        chk1("err_holds", err_unexp, 1'b1);
        @(negedge clk); mem_resp_valid = 1'b0;

        // mid-operation reset with two requests outstanding
        @(negedge clk); i_req_valid = 1'b1; i_req_addr = 32'h300;
        @(negedge clk);
        @(negedge clk); mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
        #2 reset = 1'b0;
        #1;
        chk1("mid_rst_i_ready", i_req_ready, 1'b0);
        chk1("mid_rst_d_ready", d_req_ready, 1'b0);
        chk1("mid_rst_mem_valid", mem_req_valid, 1'b0);
        chk1("mid_rst_i_resp", i_resp_valid, 1'b0);
        chk1("mid_rst_d_resp", d_resp_valid, 1'b0);
        chk1("mid_rst_err", err_unexp, 1'b0);
        @(negedge clk); reset = 1'b1;
        #1;
        chk1("post_rst_grant", i_req_ready, 1'b1);
        chk1("post_rst_resp_dropped", i_resp_valid, 1'b0);
        @(negedge clk); i_req_valid = 1'b0; mem_resp_valid = 1'b0;
        #1;
        chk1("post_rst_err", err_unexp, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 4, maximum outstanding requests (power of 2, at least 2).
REQ-004 SHALL have parameter MAX_WAIT, default 4, maximum consecutive instruction-port losses.
REQ-005 SHALL have port clk, input, 1, the single clock; all state rises on clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have, for each port x in {i, d}: x_req_valid in 1, x_req_ready out 1, x_req_addr in AW, x_req_wdata in DW, x_req_wen in 1, x_req_wmask in DW/8.
REQ-008 SHALL have, for each port x in {i, d}: x_resp_valid out 1 and x_resp_data out DW.
REQ-009 SHALL have the memory request port: mem_req_valid out 1, mem_req_ready in 1, mem_addr out AW, mem_wdata out DW, mem_wen out 1, mem_wmask out DW/8.
REQ-010 SHALL have the memory response port: mem_resp_valid in 1 and mem_resp_data in DW.
REQ-011 SHALL have err_unexp, out, 1, sticky flag for a response received with nothing outstanding.

Function
REQ-012 SHALL share the single memory port between the instruction requester (i) and the data requester (d); every request, read or write, receives exactly one response, and responses return in request order.
REQ-013 SHALL choose the winner combinationally each cycle: d wins if d_req_valid, unless starve_cnt == MAX_WAIT and i_req_valid, in which case i wins; otherwise i wins if i_req_valid.
REQ-014 SHALL disable granting when outstanding count == DEPTH; then mem_req_valid = 0 and both x_req_ready = 0, even if a response pops in the same cycle.
REQ-015 SHALL, when granting is enabled, drive mem_req_valid = winner's req_valid, drive mem_addr/wdata/wen/wmask from the winner, and set winner_req_ready = mem_req_ready; the loser's req_ready = 0.
REQ-016 SHALL hold the mem_* request fields at 0 when no request is valid.
REQ-017 SHALL count a handshake when mem_req_valid && mem_req_ready; the request passes to memory with zero added latency.
REQ-018 SHALL, on each handshake, push the winner ID (0 = i, 1 = d) into an ID FIFO of DEPTH entries with wrapping write pointer and count + 1.
REQ-019 SHALL, on mem_resp_valid with count > 0, route the response combinationally to the port named by the FIFO head: x_resp_valid = 1, x_resp_data = mem_resp_data.
REQ-020 SHALL pop the FIFO head on that response (wrapping read pointer, count - 1); the other port's resp_valid stays 0.
REQ-021 SHALL keep the count unchanged on a push and pop in the same cycle, while both pointers advance.
REQ-022 SHALL, on mem_resp_valid with count == 0, drop the response (no resp_valid), set err_unexp, and hold err_unexp until reset.
REQ-023 SHALL drive x_resp_data = 0 whenever x_resp_valid = 0.
REQ-024 SHALL update starve_cnt (0..MAX_WAIT, saturating): +1 on a cycle where i_req_valid and d completes a handshake; 0 when i completes a handshake or i_req_valid = 0; unchanged otherwise.
REQ-025 SHALL leave arbitration unaffected by the request type (wen); writes and reads are treated alike.

Reset
REQ-026 SHALL, while reset = 0, immediately clear count, pointers, starve_cnt and err_unexp to 0.
REQ-027 SHALL force all valid and ready outputs to 0 while reset = 0.
REQ-028 SHALL discard any outstanding requests on a mid-operation reset; responses arriving after reset release with count 0 fall under REQ-022.
REQ-029 SHALL begin arbitration on the first clk edge after reset deasserts.

Verification
REQ-030 SHALL cover: i-only read, addr 0x100, mem_req_ready = 1, response 0xDEADBEEF two cycles later -> i_resp_valid one cycle with data 0xDEADBEEF; d_resp_valid stays 0.
REQ-031 SHALL cover: i and d both valid continuously, mem_req_ready = 1, MAX_WAIT = 4 -> grant sequence d,d,d,d,i,d,d,d,d,i; starve_cnt never exceeds 4.
REQ-032 SHALL cover: interleaved grants i,d,d,i with responses in order 0xA,0xB,0xC,0xD -> i receives 0xA,0xD and d receives 0xB,0xC.
REQ-033 SHALL cover: 4 grants with no responses (DEPTH = 4) -> count = 4 and both req_ready = 0; a response plus a pending request in the same cycle -> no grant that cycle, grant next cycle.
REQ-034 SHALL cover: mem_resp_valid with count = 0 -> no resp_valid and err_unexp = 1; err_unexp holds through later traffic until reset.
REQ-035 SHALL cover: reset asserted with 2 requests outstanding -> outputs 0 asynchronously; after release, count = 0 and a new i request is granted.
